cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the LEGv8 CPU. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the datapath enables cycle by cycle. It also holds the fetch and data-memory phases until memory handshakes with `mem_ready`. It replaces per-instruction single-cycle control, so the ALU, register file and one shared memory port are time-multiplexed across phases.

---
 rtl/cpu_sequencer_if.sv | 43 ++++
 rtl/cpu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control-side bundle between the LEGv8 multi-cycle
// sequencer and the datapath/memory.
//   master : sequencer view (takes opcode/zero/mem_ready, drives enables,
//            state and status)
//   slave  : datapath view (the mirror image)
// Signals:
//   inst31_21 - opcode field from the instruction register
//   zero      - ALU zero flag
//   mem_ready - memory completion
//   ir_write, pc_write, pc_src, mem_read, mem_write, reg_write - enables
//   state     - current sequencer state encoding
//   halted    - high in HALT
//   illegal   - sticky unrecognised-opcode flag
//   retired   - completed-instruction counter (CNT_W bits)
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [10:0]      inst31_21;
    logic             zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  inst31_21, zero, mem_ready,
        output ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
        output state, halted, illegal, retired
    );

    modport slave (
        output inst31_21, zero, mem_ready,
        input  ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
        input  state, halted, illegal, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the LEGv8 CPU.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, driving
// the datapath enables per cycle and stalling FETCH/MEM on mem_ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - cpu_sequencer_if.master (opcode/zero/mem_ready in; enables,
//          state, halted, illegal, retired out)
// Parameter:
//   CNT_W - width of the retired-instruction counter (wraps)
// Build option:
//   CPU_SEQ_ILLEGAL_TRAP_EN - when defined, an unrecognised opcode halts
//   the sequencer instead of executing as a NOP.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_LOAD,
        C_STORE,
        C_ADDI,
        C_CBZ,
        C_CBNZ,
        C_B,
        C_HALT,
        C_ILLEGAL
    } iclass_t;

    state_t           state_q;
    iclass_t          class_q;
    iclass_t          dec_class;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;

    // casez takes the first matching item, so exact opcodes are listed
    // ahead of the wildcard families.
    always_comb begin
        dec_class = C_ILLEGAL;
        casez (bus.inst31_21)
            11'b11111000010: dec_class = C_LOAD;
            11'b11111000000: dec_class = C_STORE;
            11'b10001011000: dec_class = C_RTYPE;
            11'b11001011000: dec_class = C_RTYPE;
            11'b10001010000: dec_class = C_RTYPE;
            11'b10101010000: dec_class = C_RTYPE;
            11'b11111111111: dec_class = C_HALT;
            11'b1001000100?: dec_class = C_ADDI;
            11'b10110100???: dec_class = C_CBZ;
            11'b10110101???: dec_class = C_CBNZ;
            11'b000101?????: dec_class = C_B;
            default:         dec_class = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_RTYPE;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    class_q <= dec_class;
                    case (dec_class)
                        C_HALT: begin
                            state_q   <= S_HALT;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                        C_ILLEGAL: begin
                            illegal_q <= 1'b1;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                            state_q   <= S_HALT;
`else
                            state_q   <= S_EXEC;
`endif
                        end
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (class_q)
                        C_RTYPE, C_ADDI: state_q <= S_WB;
                        C_LOAD, C_STORE: state_q <= S_MEM;
                        // Branches and the illegal-as-NOP case finish here.
                        default: begin
                            state_q   <= S_FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (class_q == C_LOAD) begin
                            state_q <= S_WB;
                        end else begin
                            state_q   <= S_FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    retired_q <= retired_q + CNT_W'(1);
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Enables are decoded from state/class; mem_ready and zero are the only
    // inputs that reach the outputs combinationally.
    always_comb begin
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.reg_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            S_EXEC: begin
                case (class_q)
                    C_B: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 1'b1;
                    end
                    C_CBZ: begin
                        bus.pc_write = bus.zero;
                        bus.pc_src   = 1'b1;
                    end
                    C_CBNZ: begin
                        bus.pc_write = ~bus.zero;
                        bus.pc_src   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_read  = (class_q == C_LOAD);
                bus.mem_write = (class_q == C_STORE);
            end
            S_WB: bus.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.halted  = (state_q == S_HALT);
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.
// A default-width instance and a CNT_W=4 instance share clock, reset and
// inputs, so the narrow one exposes counter wrap on the same stimulus.
module tb_cpu_sequencer;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001001;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_HALT = 11'b11111111111;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    // {ir_write, pc_write, pc_src, mem_read, mem_write, reg_write}
    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_FETCH = 6'b110100;
    localparam logic [5:0] EN_FWAIT = 6'b000100;
    localparam logic [5:0] EN_LD    = 6'b000100;
    localparam logic [5:0] EN_ST    = 6'b000010;
    localparam logic [5:0] EN_WB    = 6'b000001;
    localparam logic [5:0] EN_BR    = 6'b011000;
    localparam logic [5:0] EN_NBR   = 6'b001000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ret  = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(16)) bus ();
    cpu_sequencer_if #(.CNT_W(4))  bus4 ();

    cpu_sequencer #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    cpu_sequencer #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.inst31_21 = bus.inst31_21;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] en_vec();
        return {bus.ir_write, bus.pc_write, bus.pc_src,
                bus.mem_read, bus.mem_write, bus.reg_write};
    endfunction

    // Apply inputs, check state/enables mid-cycle, advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] en,
                       input logic rdy, input logic z);
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
        check({tag, " state"}, 32'(bus.state), 32'(st));
        check({tag, " en"}, 32'(en_vec()), 32'(en));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ret(input string tag);
        logic [15:0] e16;
        logic [3:0]  e4;
        e16 = exp_ret[15:0];
        e4  = exp_ret[3:0];
        check({tag, " retired"}, 32'(bus.retired), 32'(e16));
        check({tag, " retired4"}, 32'(bus4.retired), 32'(e4));
    endtask

    initial begin
        rst           = 1'b1;
        bus.inst31_21 = OP_ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset en", 32'(en_vec()), 32'(EN_FWAIT));
        check("reset halted", 32'(bus.halted), 32'd0);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        chk_ret("reset");
        rst = 1'b0;

        // ADD: 0,1,2,4 then back to 0
        bus.inst31_21 = OP_ADD;
        cyc("add f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("add d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("add e", 3'd2, EN_NONE,  1'b1, 1'b0);
        cyc("add w", 3'd4, EN_WB,    1'b1, 1'b0);
        exp_ret = 1;
        chk_ret("add");

        // LDUR with three MEM wait cycles: 8 cycles total
        bus.inst31_21 = OP_LDUR;
        cyc("ld f",  3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("ld d",  3'd1, EN_NONE,  1'b0, 1'b0);
        cyc("ld e",  3'd2, EN_NONE,  1'b0, 1'b0);
        cyc("ld m0", 3'd3, EN_LD,    1'b0, 1'b0);
        cyc("ld m1", 3'd3, EN_LD,    1'b0, 1'b0);
        cyc("ld m2", 3'd3, EN_LD,    1'b0, 1'b0);
        cyc("ld m3", 3'd3, EN_LD,    1'b1, 1'b0);
        cyc("ld w",  3'd4, EN_WB,    1'b0, 1'b0);
        exp_ret = 2;
        chk_ret("ldur");

        // CBZ taken, then not taken
        bus.inst31_21 = OP_CBZ;
        cyc("cbz1 f", 3'd0, EN_FETCH, 1'b1, 1'b1);
        cyc("cbz1 d", 3'd1, EN_NONE,  1'b1, 1'b1);
        cyc("cbz1 e", 3'd2, EN_BR,    1'b1, 1'b1);
        exp_ret = 3;
        chk_ret("cbz1");
        cyc("cbz0 f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("cbz0 d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("cbz0 e", 3'd2, EN_NBR,   1'b1, 1'b0);
        exp_ret = 4;
        chk_ret("cbz0");

        // CBNZ with zero=0 is taken
        bus.inst31_21 = OP_CBNZ;
        cyc("cbnz f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("cbnz d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("cbnz e", 3'd2, EN_BR,    1'b1, 1'b0);
        exp_ret = 5;
        chk_ret("cbnz");

        // B is unconditional regardless of zero
        bus.inst31_21 = OP_B;
        cyc("b f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("b d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("b e", 3'd2, EN_BR,    1'b1, 1'b0);
        exp_ret = 6;
        chk_ret("b");

        // STUR with one FETCH wait cycle
        bus.inst31_21 = OP_STUR;
        cyc("st fw", 3'd0, EN_FWAIT, 1'b0, 1'b0);
        cyc("st f",  3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("st d",  3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("st e",  3'd2, EN_NONE,  1'b1, 1'b0);
        cyc("st m",  3'd3, EN_ST,    1'b1, 1'b0);
        exp_ret = 7;
        chk_ret("stur");

        // ADDI (wildcard low bit set)
        bus.inst31_21 = OP_ADDI;
        cyc("addi f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("addi d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("addi e", 3'd2, EN_NONE,  1'b1, 1'b0);
        cyc("addi w", 3'd4, EN_WB,    1'b1, 1'b0);
        exp_ret = 8;
        chk_ret("addi");

        // Unrecognised opcode
        bus.inst31_21 = OP_ILL;
        cyc("ill f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("ill d", 3'd1, EN_NONE,  1'b1, 1'b0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check("ill illegal", 32'(bus.illegal), 32'd1);
        check("ill halted", 32'(bus.halted), 32'd1);
        chk_ret("ill");
`else
        cyc("ill e", 3'd2, EN_NONE,  1'b1, 1'b0);
        exp_ret = 9;
        chk_ret("ill");
        check("ill illegal", 32'(bus.illegal), 32'd1);
        check("ill halted", 32'(bus.halted), 32'd0);

        bus.inst31_21 = OP_HALT;
        cyc("halt f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("halt d", 3'd1, EN_NONE,  1'b1, 1'b0);
        exp_ret = 10;
        chk_ret("halt");
`endif

        // HALT is terminal even with mem_ready high and opcodes changing
        bus.inst31_21 = OP_ADD;
        for (int i = 0; i < 20; i++) begin
            cyc("halt idle", 3'd5, EN_NONE, 1'b1, 1'b1);
            check("halt idle halted", 32'(bus.halted), 32'd1);
        end
        chk_ret("halt idle");

        // Reset pulse leaves HALT and clears counters/flags
        rst = 1'b1;
        #1;
        exp_ret = 0;
        check("rst state", 32'(bus.state), 32'd0);
        check("rst halted", 32'(bus.halted), 32'd0);
        check("rst illegal", 32'(bus.illegal), 32'd0);
        chk_ret("rst");
        @(negedge clk);
        rst = 1'b0;

        // 17 ADDs: narrow counter wraps 15 -> 0 and lands on 1
        bus.inst31_21 = OP_ADD;
        for (int n = 0; n < 17; n++) begin
            cyc("wrap f", 3'd0, EN_FETCH, 1'b1, 1'b0);
            cyc("wrap d", 3'd1, EN_NONE,  1'b1, 1'b0);
            cyc("wrap e", 3'd2, EN_NONE,  1'b1, 1'b0);
            cyc("wrap w", 3'd4, EN_WB,    1'b1, 1'b0);
            exp_ret++;
            chk_ret("wrap");
        end

        // Reset during a stalled STUR MEM phase aborts the write at once
        bus.inst31_21 = OP_STUR;
        cyc("stab f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("stab d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("stab e", 3'd2, EN_NONE,  1'b0, 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        check("stab mem state", 32'(bus.state), 32'd3);
        check("stab mem write", 32'(bus.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_ret = 0;
        check("stab rst state", 32'(bus.state), 32'd0);
        check("stab rst write", 32'(bus.mem_write), 32'd0);
        check("stab rst write4", 32'(bus4.mem_write), 32'd0);
        check("stab rst en", 32'(en_vec()), 32'(EN_FWAIT));
        chk_ret("stab rst");
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes after the abort
        bus.inst31_21 = OP_ADD;
        cyc("post f", 3'd0, EN_FETCH, 1'b1, 1'b0);
        cyc("post d", 3'd1, EN_NONE,  1'b1, 1'b0);
        cyc("post e", 3'd2, EN_NONE,  1'b1, 1'b0);
        cyc("post w", 3'd4, EN_WB,    1'b1, 1'b0);
        exp_ret = 1;
        chk_ret("post");
        check("post state", 32'(bus.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
